riscv_wb_arbiter: RTL and testbench

//  Write-back arbiter feeding the two integer/FP register-file write ports (A, B).
//  - Merges three result sources: EX (single-cycle ALU), LSU (load data), APU (long-latency mult/div/FPU).
//  - Buffers APU results in a small FIFO, drives registered we/waddr/wdata pairs to the register file.
//  - Exports a per-register pending-write vector for ID-stage hazard checks.

---
 rtl/riscv_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: EX/LSU/APU results onto register-file ports A/B.
// Optional WB_APU_BYPASS_EN lets APU results skip an empty FIFO.
module riscv_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_we_i,
    input  logic [ADDR_WIDTH-1:0]      ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]      ex_wdata_i,
    input  logic                       lsu_we_i,
    input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
    input  logic                       apu_valid_i,
    output logic                       apu_ready_o,
    input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      apu_wdata_i,
    output logic                       we_a_o,
    output logic [ADDR_WIDTH-1:0]      waddr_a_o,
    output logic [DATA_WIDTH-1:0]      wdata_a_o,
    output logic                       we_b_o,
    output logic [ADDR_WIDTH-1:0]      waddr_b_o,
    output logic [DATA_WIDTH-1:0]      wdata_b_o,
    output logic [2**ADDR_WIDTH-1:0]   pend_o
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int NREG = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

    fifo_state_e           fifo_state;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [CW-1:0]         pcnt_q [NREG];
    logic [CW-1:0]         pcnt_d [NREG];

    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic                  apu_wb_q, apu_wb_d;
    logic [ADDR_WIDTH-1:0] apu_wb_addr_q, apu_wb_addr_d;

    logic ex_wr, lsu_wr, apu_wr, head_valid;
    logic pop_a, pop_b, pop, push, byp_a, byp_b;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    always_comb begin
        if (count_q == '0)
            fifo_state = FIFO_EMPTY;
        else if (count_q == CW'(FIFO_DEPTH))
            fifo_state = FIFO_FULL;
        else
            fifo_state = FIFO_PARTIAL;

        apu_ready_o = !rst && (fifo_state != FIFO_FULL);
        head_valid  = (fifo_state != FIFO_EMPTY);
        head_addr   = mem_addr_q[rd_ptr_q];
        head_data   = mem_data_q[rd_ptr_q];

        // Address 0 writes are accepted but never reach a port or the FIFO.
        ex_wr  = ex_we_i && (ex_waddr_i != '0);
        lsu_wr = lsu_we_i && (lsu_waddr_i != '0);
        apu_wr = apu_valid_i && apu_ready_o && (apu_waddr_i != '0);

        pop_b = head_valid && !lsu_we_i;
        pop_a = head_valid && lsu_we_i && !ex_we_i;
        pop   = pop_a || pop_b;
`ifdef WB_APU_BYPASS_EN
        byp_b = apu_wr && !head_valid && !lsu_we_i;
        byp_a = apu_wr && !head_valid && lsu_we_i && !ex_we_i;
`else
        byp_b = 1'b0;
        byp_a = 1'b0;
`endif
        push = apu_wr && !byp_a && !byp_b;

        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);

        we_a_d    = ex_wr || pop_a || byp_a;
        waddr_a_d = '0;
        wdata_a_d = '0;
        unique case (1'b1)
            ex_wr: begin waddr_a_d = ex_waddr_i;  wdata_a_d = ex_wdata_i;  end
            pop_a: begin waddr_a_d = head_addr;   wdata_a_d = head_data;   end
            byp_a: begin waddr_a_d = apu_waddr_i; wdata_a_d = apu_wdata_i; end
            default: ;
        endcase

        we_b_d    = lsu_wr || pop_b || byp_b;
        waddr_b_d = '0;
        wdata_b_d = '0;
        unique case (1'b1)
            lsu_wr: begin waddr_b_d = lsu_waddr_i; wdata_b_d = lsu_wdata_i; end
            pop_b:  begin waddr_b_d = head_addr;   wdata_b_d = head_data;   end
            byp_b:  begin waddr_b_d = apu_waddr_i; wdata_b_d = apu_wdata_i; end
            default: ;
        endcase

        apu_wb_d      = pop || byp_a || byp_b;
        apu_wb_addr_d = pop ? head_addr : apu_waddr_i;

        // Count up on acceptance, down once the APU write has left the output regs.
        for (int r = 0; r < NREG; r++) begin
            pcnt_d[r] = pcnt_q[r];
            if (apu_wr && apu_waddr_i == ADDR_WIDTH'(r))
                pcnt_d[r] = pcnt_d[r] + CW'(1);
            if (apu_wb_q && apu_wb_addr_q == ADDR_WIDTH'(r))
                pcnt_d[r] = pcnt_d[r] - CW'(1);
            pend_o[r] = (pcnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            we_a_q        <= 1'b0;
            waddr_a_q     <= '0;
            wdata_a_q     <= '0;
            we_b_q        <= 1'b0;
            waddr_b_q     <= '0;
            wdata_b_q     <= '0;
            apu_wb_q      <= 1'b0;
            apu_wb_addr_q <= '0;
            for (int r = 0; r < NREG; r++) pcnt_q[r] <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            we_a_q        <= we_a_d;
            waddr_a_q     <= waddr_a_d;
            wdata_a_q     <= wdata_a_d;
            we_b_q        <= we_b_d;
            waddr_b_q     <= waddr_b_d;
            wdata_b_q     <= wdata_b_d;
            apu_wb_q      <= apu_wb_d;
            apu_wb_addr_q <= apu_wb_addr_d;
            for (int r = 0; r < NREG; r++) pcnt_q[r] <= pcnt_d[r];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= apu_waddr_i;
            mem_data_q[wr_ptr_q] <= apu_wdata_i;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;

    ex_pend_chk: assert property (@(posedge clk) disable iff (rst)
        (ex_we_i && ex_waddr_i != '0) |-> !pend_o[ex_waddr_i]);
    lsu_pend_chk: assert property (@(posedge clk) disable iff (rst)
        (lsu_we_i && lsu_waddr_i != '0) |-> !pend_o[lsu_waddr_i]);
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: vector table plus multi-cycle sequences.
module tb_riscv_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we_i, lsu_we_i, apu_valid_i, apu_ready_o;
    logic [5:0]  ex_waddr_i, lsu_waddr_i, apu_waddr_i;
    logic [31:0] ex_wdata_i, lsu_wdata_i, apu_wdata_i;
    logic        we_a_o, we_b_o;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic [63:0] pend_o;

    int checks = 0;
    int errors = 0;

    riscv_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .apu_valid_i(apu_valid_i), .apu_ready_o(apu_ready_o),
        .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .pend_o(pend_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ex_we;
        logic [5:0]  ex_a;
        logic [31:0] ex_d;
        logic        lsu_we;
        logic [5:0]  lsu_a;
        logic [31:0] lsu_d;
        logic        we_a;
        logic [5:0]  wa;
        logic [31:0] da;
        logic        we_b;
        logic [5:0]  wb;
        logic [31:0] db;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        apu_valid_i = 0; apu_waddr_i = 0; apu_wdata_i = 0;
    endtask

    task automatic chk_port_a(input string name, input logic [5:0] a, input logic [31:0] d);
        chk({name, "_we_a"}, 64'(we_a_o), 64'd1);
        chk({name, "_waddr_a"}, 64'(waddr_a_o), 64'(a));
        chk({name, "_wdata_a"}, 64'(wdata_a_o), 64'(d));
    endtask

    task automatic chk_port_b(input string name, input logic [5:0] a, input logic [31:0] d);
        chk({name, "_we_b"}, 64'(we_b_o), 64'd1);
        chk({name, "_waddr_b"}, 64'(waddr_b_o), 64'(a));
        chk({name, "_wdata_b"}, 64'(wdata_b_o), 64'(d));
    endtask

    initial begin
        vecs[0] = '{1, 6'd5,  32'hDEADBEEF, 1, 6'd6,  32'h12345678,
                    1, 6'd5,  32'hDEADBEEF, 1, 6'd6,  32'h12345678};
        vecs[1] = '{1, 6'd1,  32'h00000001, 0, 6'd0,  32'h0,
                    1, 6'd1,  32'h00000001, 0, 6'd0,  32'h0};
        vecs[2] = '{0, 6'd0,  32'h0,        1, 6'd31, 32'hFFFFFFFF,
                    0, 6'd0,  32'h0,        1, 6'd31, 32'hFFFFFFFF};
        vecs[3] = '{1, 6'd0,  32'h00005555, 1, 6'd3,  32'h00000077,
                    0, 6'd0,  32'h0,        1, 6'd3,  32'h00000077};
        vecs[4] = '{1, 6'd8,  32'h00000011, 1, 6'd8,  32'h00000022,
                    1, 6'd8,  32'h00000011, 1, 6'd8,  32'h00000022};
        vecs[5] = '{1, 6'd33, 32'h0000CAFE, 1, 6'd0,  32'h0000BEEF,
                    1, 6'd33, 32'h0000CAFE, 0, 6'd0,  32'h0};
        vecs[6] = '{0, 6'd0,  32'h0,        0, 6'd0,  32'h0,
                    0, 6'd0,  32'h0,        0, 6'd0,  32'h0};

        // Reset held two cycles with every valid asserted.
        rst = 1;
        ex_we_i = 1; ex_waddr_i = 6'd4; ex_wdata_i = 32'h44;
        lsu_we_i = 1; lsu_waddr_i = 6'd5; lsu_wdata_i = 32'h55;
        apu_valid_i = 1; apu_waddr_i = 6'd3; apu_wdata_i = 32'h33;
        tick();
        tick();
        chk("rst_ready", 64'(apu_ready_o), 64'd0);
        chk("rst_we_a", 64'(we_a_o), 64'd0);
        chk("rst_we_b", 64'(we_b_o), 64'd0);
        chk("rst_waddr_a", 64'(waddr_a_o), 64'd0);
        chk("rst_wdata_b", 64'(wdata_b_o), 64'd0);
        chk("rst_pend", pend_o, 64'd0);
        rst = 0;
        idle_inputs();
        tick();
        chk("post_rst_we_a", 64'(we_a_o), 64'd0);
        chk("post_rst_we_b", 64'(we_b_o), 64'd0);
        chk("post_rst_pend", pend_o, 64'd0);
        chk("post_rst_ready", 64'(apu_ready_o), 64'd1);

        // Single-cycle EX/LSU vectors.
        for (int i = 0; i < 7; i++) begin
            ex_we_i = vecs[i].ex_we; ex_waddr_i = vecs[i].ex_a; ex_wdata_i = vecs[i].ex_d;
            lsu_we_i = vecs[i].lsu_we; lsu_waddr_i = vecs[i].lsu_a; lsu_wdata_i = vecs[i].lsu_d;
            tick();
            chk($sformatf("vec%0d_we_a", i), 64'(we_a_o), 64'(vecs[i].we_a));
            chk($sformatf("vec%0d_we_b", i), 64'(we_b_o), 64'(vecs[i].we_b));
            if (vecs[i].we_a) begin
                chk($sformatf("vec%0d_waddr_a", i), 64'(waddr_a_o), 64'(vecs[i].wa));
                chk($sformatf("vec%0d_wdata_a", i), 64'(wdata_a_o), 64'(vecs[i].da));
            end
            if (vecs[i].we_b) begin
                chk($sformatf("vec%0d_waddr_b", i), 64'(waddr_b_o), 64'(vecs[i].wb));
                chk($sformatf("vec%0d_wdata_b", i), 64'(wdata_b_o), 64'(vecs[i].db));
            end
        end
        idle_inputs();
        tick();

        // APU x7 with free ports.
        apu_valid_i = 1; apu_waddr_i = 6'd7; apu_wdata_i = 32'hA5A5A5A5;
        chk("apu7_ready", 64'(apu_ready_o), 64'd1);
        tick();
        idle_inputs();
`ifdef WB_APU_BYPASS_EN
        chk_port_b("apu7", 6'd7, 32'hA5A5A5A5);
        chk("apu7_pend_set", pend_o, 64'h80);
        tick();
`else
        chk("apu7_early_we_b", 64'(we_b_o), 64'd0);
        chk("apu7_pend_q", pend_o, 64'h80);
        tick();
        chk_port_b("apu7", 6'd7, 32'hA5A5A5A5);
        chk("apu7_pend_set", pend_o, 64'h80);
        tick();
`endif
        chk("apu7_pend_clr", pend_o, 64'd0);
        chk("apu7_we_b_off", 64'(we_b_o), 64'd0);

        // Fill the FIFO while both ports are busy.
        ex_we_i = 1; ex_waddr_i = 6'd10; ex_wdata_i = 32'h10;
        lsu_we_i = 1; lsu_waddr_i = 6'd11; lsu_wdata_i = 32'h11;
        for (int i = 0; i < 4; i++) begin
            apu_valid_i = 1; apu_waddr_i = 6'(20 + i); apu_wdata_i = 32'h100 + 32'(i);
            tick();
        end
        chk("full_ready", 64'(apu_ready_o), 64'd0);
        chk("full_pend", pend_o, 64'h0000_0000_00F0_0000);
        apu_waddr_i = 6'd24; apu_wdata_i = 32'hBAD;
        tick();
        chk("full_reject_pend", pend_o, 64'h0000_0000_00F0_0000);
        chk("full_still_ready0", 64'(apu_ready_o), 64'd0);
        chk_port_a("full_ex", 6'd10, 32'h10);
        apu_valid_i = 0;
        ex_we_i = 0;
        tick();
        chk_port_a("drain0", 6'd20, 32'h100);
        chk_port_b("drain0_lsu", 6'd11, 32'h11);
        chk("drain0_ready", 64'(apu_ready_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_port_a($sformatf("drain%0d", i), 6'(20 + i), 32'h100 + 32'(i));
            chk($sformatf("drain%0d_pend", i), 64'(pend_o[19 + i]), 64'd0);
            chk($sformatf("drain%0d_pend_cur", i), 64'(pend_o[20 + i]), 64'd1);
        end
        tick();
        chk("drained_we_a", 64'(we_a_o), 64'd0);
        tick();
        chk("drained_pend", pend_o, 64'd0);
        idle_inputs();
        tick();

        // Writes to x0 from APU and EX are swallowed.
        apu_valid_i = 1; apu_waddr_i = 6'd0; apu_wdata_i = 32'h1234;
        ex_we_i = 1; ex_waddr_i = 6'd0; ex_wdata_i = 32'h5678;
        tick();
        idle_inputs();
        chk("x0_we_a", 64'(we_a_o), 64'd0);
        chk("x0_we_b", 64'(we_b_o), 64'd0);
        chk("x0_pend", pend_o, 64'd0);
        chk("x0_ready", 64'(apu_ready_o), 64'd1);
        tick();
        chk("x0_late_we_a", 64'(we_a_o), 64'd0);
        chk("x0_late_we_b", 64'(we_b_o), 64'd0);

        // Two queued x9 results, reset after the first drains.
        ex_we_i = 1; ex_waddr_i = 6'd12; ex_wdata_i = 32'h12;
        lsu_we_i = 1; lsu_waddr_i = 6'd13; lsu_wdata_i = 32'h13;
        apu_valid_i = 1; apu_waddr_i = 6'd9; apu_wdata_i = 32'h99;
        tick();
        apu_wdata_i = 32'h98;
        tick();
        apu_valid_i = 0;
        chk("x9_pend", pend_o, 64'h200);
        ex_we_i = 0; lsu_we_i = 0;
        tick();
        chk_port_b("x9_first", 6'd9, 32'h99);
        chk("x9_pend_mid", 64'(pend_o[9]), 64'd1);
        rst = 1;
        tick();
        chk("x9_rst_we_a", 64'(we_a_o), 64'd0);
        chk("x9_rst_we_b", 64'(we_b_o), 64'd0);
        chk("x9_rst_pend", pend_o, 64'd0);
        chk("x9_rst_ready", 64'(apu_ready_o), 64'd0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("x9_after%0d_we_a", i), 64'(we_a_o), 64'd0);
            chk($sformatf("x9_after%0d_we_b", i), 64'(we_b_o), 64'd0);
            chk($sformatf("x9_after%0d_pend", i), pend_o, 64'd0);
        end
        chk("x9_after_ready", 64'(apu_ready_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
